// File: rtl/gg_nal_packer.sv
// Annex-B NAL packer: start code, header byte, then the RBSP payload with
// emulation-prevention 0x03 bytes inserted and a trailing 0x03 after a final 0x00.
module gg_nal_packer #(
  parameter bit LONG_START = 1'b1,
  parameter int CNT_W      = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nal_start,
  input  logic [7:0]       nal_hdr,
  output logic             busy,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic [CNT_W-1:0] byte_count,
  output logic [15:0]      epb_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SC   = 3'd1,
    HDR  = 3'd2,
    DATA = 3'd3,
    TAIL = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [1:0] SC_LAST = LONG_START ? 2'd3 : 2'd2;

  state_t           state_r;
  logic [1:0]       sc_idx_r;
  logic [1:0]       zero_cnt_r;
  logic [7:0]       hdr_r;
  logic [7:0]       out_data_r;
  logic             out_valid_r;
  logic             out_first_r;
  logic             out_last_r;
  logic             busy_r;
  logic [CNT_W-1:0] byte_count_r;
  logic [15:0]      epb_count_r;
  logic             load_slot_s;
  logic             xfer_s;
  logic             epb_needed_s;

  // Two zeros already emitted followed by a byte <= 0x03 would fake a start code.
  function automatic logic needs_epb(input logic [1:0] zc, input logic v, input logic [7:0] d);
    return (zc == 2'd2) && v && (d <= 8'h03);
  endfunction

  assign load_slot_s  = !out_valid_r || out_ready;
  assign xfer_s       = out_valid_r && out_ready;
  assign epb_needed_s = (state_r == DATA) && needs_epb(zero_cnt_r, in_valid, in_data);

  assign in_ready   = (state_r == DATA) && load_slot_s && !epb_needed_s;
  assign busy       = busy_r;
  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign out_first  = out_first_r;
  assign out_last   = out_last_r;
  assign byte_count = byte_count_r;
  assign epb_count  = epb_count_r;

  // Packer FSM with single-register output stage and per-NAL counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      sc_idx_r     <= 2'd0;
      zero_cnt_r   <= 2'd0;
      hdr_r        <= 8'h00;
      out_data_r   <= 8'h00;
      out_valid_r  <= 1'b0;
      out_first_r  <= 1'b0;
      out_last_r   <= 1'b0;
      busy_r       <= 1'b0;
      byte_count_r <= '0;
      epb_count_r  <= 16'd0;
    end else begin
      if (xfer_s) begin
        byte_count_r <= byte_count_r + CNT_W'(1);
      end
      // An empty load slot drops the stage unless a state below refills it.
      if (load_slot_s) begin
        out_valid_r <= 1'b0;
        out_first_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (nal_start) begin
            hdr_r        <= nal_hdr;
            byte_count_r <= '0;
            epb_count_r  <= 16'd0;
            sc_idx_r     <= 2'd0;
            busy_r       <= 1'b1;
            state_r      <= SC;
          end
        end
        SC: begin
          if (load_slot_s) begin
            out_data_r  <= (sc_idx_r == SC_LAST) ? 8'h01 : 8'h00;
            out_valid_r <= 1'b1;
            out_first_r <= (sc_idx_r == 2'd0);
            if (sc_idx_r == SC_LAST) begin
              state_r <= HDR;
            end else begin
              sc_idx_r <= sc_idx_r + 2'd1;
            end
          end
        end
        HDR: begin
          if (load_slot_s) begin
            out_data_r  <= hdr_r;
            out_valid_r <= 1'b1;
            zero_cnt_r  <= 2'd0;
            state_r     <= DATA;
          end
        end
        DATA: begin
          if (load_slot_s) begin
            if (epb_needed_s) begin
              out_data_r  <= 8'h03;
              out_valid_r <= 1'b1;
              epb_count_r <= epb_count_r + 16'd1;
              zero_cnt_r  <= 2'd0;
            end else if (in_valid) begin
              out_data_r  <= in_data;
              out_valid_r <= 1'b1;
              if (in_data == 8'h00) begin
                zero_cnt_r <= (zero_cnt_r == 2'd2) ? 2'd2 : zero_cnt_r + 2'd1;
              end else begin
                zero_cnt_r <= 2'd0;
              end
              if (in_last) begin
                if (in_data == 8'h00) begin
                  state_r <= TAIL;
                end else begin
                  out_last_r <= 1'b1;
                  state_r    <= DONE;
                end
              end
            end
          end
        end
        TAIL: begin
          if (load_slot_s) begin
            out_data_r  <= 8'h03;
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b1;
            epb_count_r <= epb_count_r + 16'd1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (xfer_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gg_nal_packer.sv
// Bench for gg_nal_packer: a byte-stream model of Annex-B packing, a per-cycle
// output monitor, and directed NALs on both start-code lengths.
module tb_gg_nal_packer;
  localparam int CW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, sel, nal_start, in_valid, in_last, out_ready;
  logic [7:0]    nal_hdr, in_data;
  logic          busy_a, busy_b, ir_a, ir_b, ov_a, ov_b, of_a, of_b, ol_a, ol_b;
  logic [7:0]    od_a, od_b;
  logic [CW-1:0] bc_a, bc_b;
  logic [15:0]   ec_a, ec_b;

  gg_nal_packer #(.LONG_START(1'b1), .CNT_W(CW)) dut_long (
    .clk(clk), .reset(reset), .nal_start(nal_start & ~sel), .nal_hdr(nal_hdr), .busy(busy_a),
    .in_data(in_data), .in_valid(in_valid & ~sel), .in_last(in_last), .in_ready(ir_a),
    .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready), .out_first(of_a), .out_last(ol_a),
    .byte_count(bc_a), .epb_count(ec_a));

  gg_nal_packer #(.LONG_START(1'b0), .CNT_W(CW)) dut_short (
    .clk(clk), .reset(reset), .nal_start(nal_start & sel), .nal_hdr(nal_hdr), .busy(busy_b),
    .in_data(in_data), .in_valid(in_valid & sel), .in_last(in_last), .in_ready(ir_b),
    .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready), .out_first(of_b), .out_last(ol_b),
    .byte_count(bc_b), .epb_count(ec_b));

  logic          busy, in_ready, out_valid, out_first, out_last;
  logic [7:0]    out_data;
  logic [CW-1:0] byte_count;
  logic [15:0]   epb_count;
  assign busy       = sel ? busy_b : busy_a;
  assign in_ready   = sel ? ir_b   : ir_a;
  assign out_valid  = sel ? ov_b   : ov_a;
  assign out_first  = sel ? of_b   : of_a;
  assign out_last   = sel ? ol_b   : ol_a;
  assign out_data   = sel ? od_b   : od_a;
  assign byte_count = sel ? bc_b   : bc_a;
  assign epb_count  = sel ? ec_b   : ec_a;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];   // {first, last, data}
  int  exp_len, exp_epb, hdr_pos, popped, stalls;
  bit  exp_tail, hdr_seen, mon_en, rand_ready, prev_hold;
  logic [9:0] prev_word;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected Annex-B stream from the packing rules, byte by byte.
  task automatic build_model(input bit long_sc, input logic [7:0] hdr, input logic [7:0] pl[$]);
    int z;
    logic [9:0] e;
    exp_q.delete();
    exp_epb  = 0;
    exp_tail = 1'b0;
    z        = 0;
    exp_q.push_back({2'b10, 8'h00});
    exp_q.push_back({2'b00, 8'h00});
    if (long_sc) exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h01});
    hdr_pos = exp_q.size();
    exp_q.push_back({2'b00, hdr});
    foreach (pl[i]) begin
      if (z >= 2 && pl[i] <= 8'h03) begin
        exp_q.push_back({2'b00, 8'h03});
        exp_epb++;
        z = 0;
      end
      exp_q.push_back({2'b00, pl[i]});
      z = (pl[i] == 8'h00) ? ((z < 2) ? z + 1 : 2) : 0;
    end
    if (pl[pl.size()-1] == 8'h00) begin
      exp_q.push_back({2'b01, 8'h03});
      exp_epb++;
      exp_tail = 1'b1;
    end else begin
      e = exp_q.pop_back();
      exp_q.push_back(e | 10'h100);
    end
    exp_len = exp_q.size();
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: hold stability, byte-by-byte stream check, EPB stall count.
  always @(negedge clk) begin
    logic [9:0] e;
    if (mon_en) begin
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_word", {out_first, out_last, out_data}, prev_word);
      end
      if (out_valid && popped == hdr_pos) hdr_seen = 1'b1;
      if (hdr_seen && in_valid && !in_ready && (!out_valid || out_ready)) stalls++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", {out_first, out_last, out_data}, 10'h3ff);
        end else begin
          e = exp_q.pop_front();
          popped++;
          chk("out_byte", {out_first, out_last, out_data}, e);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_word = {out_first, out_last, out_data};
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic feed(input logic [7:0] b, input bit last, input bit gaps, input bit spam);
    bit acc;
    int to;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; nal_start = spam;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1; in_data = b; in_last = last; nal_start = spam;
    to = 0;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      to++;
    end while (!acc && to < 200);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_nal(input bit s, input logic [7:0] hdr, input logic [7:0] pl[$],
                          input bit rr, input bit gaps, input bit spam);
    int to;
    sel = s; rand_ready = rr;
    build_model(!s, hdr, pl);
    popped = 0; hdr_seen = 1'b0; stalls = 0; mon_en = 1'b1;
    nal_hdr = hdr; nal_start = 1'b1;
    @(posedge clk); #1;
    nal_start = 1'b0;
    chk("busy_rise", busy, 1);
    if (spam) nal_hdr = 8'hAA;
    foreach (pl[i]) feed(pl[i], i == pl.size() - 1, gaps, spam);
    in_valid = 1'b0; in_last = 1'b0; nal_start = 1'b0;
    to = 0;
    while (busy && to < 500) begin
      @(posedge clk); #1;
      to++;
    end
    chk("busy_fall", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("byte_count", byte_count, exp_len);
    chk("epb_count", epb_count, exp_epb);
    chk("epb_stalls", stalls, exp_epb - int'(exp_tail));
  endtask

  logic [7:0] p1[$], p2[$], p3[$], p4[$];

  initial begin
    reset = 1'b1; sel = 1'b0; nal_start = 1'b0; nal_hdr = 8'h00; in_data = 8'h00;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; rand_ready = 1'b0; mon_en = 1'b0;
    prev_hold = 1'b0; prev_word = 10'h000; popped = 0; hdr_pos = 0; stalls = 0; hdr_seen = 1'b0;
    p1 = '{8'h9A, 8'h80};
    p2 = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h04, 8'h7F};
    p3 = '{8'h00, 8'h00, 8'h00, 8'h00};
    p4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (3) @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      @(negedge clk);
      chk("rst_out", {out_valid, out_first, out_last, out_data}, 0);
      chk("rst_busy_ready", {busy, in_ready}, 0);
      chk("rst_counts", {byte_count, epb_count}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    send_nal(1'b0, 8'h41, p1, 1'b0, 1'b0, 1'b0);
    chk("lit1_len", byte_count, 7);
    chk("lit1_epb", epb_count, 0);
    send_nal(1'b1, 8'h65, p2, 1'b0, 1'b0, 1'b0);
    chk("lit2_len", byte_count, 16);
    chk("lit2_epb", epb_count, 2);
    send_nal(1'b0, 8'h41, p3, 1'b0, 1'b0, 1'b0);
    chk("lit3_len", byte_count, 11);
    chk("lit3_epb", epb_count, 2);

    send_nal(1'b0, 8'h41, p1, 1'b1, 1'b1, 1'b0);
    send_nal(1'b1, 8'h65, p2, 1'b1, 1'b1, 1'b0);
    send_nal(1'b0, 8'h41, p3, 1'b1, 1'b1, 1'b0);
    send_nal(1'b1, 8'h41, p3, 1'b1, 1'b1, 1'b0);
    chk("lit4_len", byte_count, 10);

    send_nal(1'b0, 8'h41, p1, 1'b1, 1'b1, 1'b1);
    chk("spam_len", byte_count, 7);

    // Abandon a NAL after three payload bytes.
    sel = 1'b0; rand_ready = 1'b0;
    build_model(1'b1, 8'h21, p4);
    popped = 0; hdr_seen = 1'b0; mon_en = 1'b1;
    nal_hdr = 8'h21; nal_start = 1'b1;
    @(posedge clk); #1;
    nal_start = 1'b0;
    for (int i = 0; i < 3; i++) feed(p4[i], 1'b0, 1'b0, 1'b0);
    reset = 1'b1; mon_en = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_counts", {byte_count, epb_count}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_quiet", out_valid, 0);
    end
    @(posedge clk); #1;
    send_nal(1'b0, 8'h41, p1, 1'b0, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
